// File: rtl/ssd1306_spi_rx_if.sv
// Byte stream from the SPI capture front end to the SSD1306 command/GRAM decoder.
// The capture block drives the master side; the decoder is the slave and drives byte_ready.
interface ssd1306_spi_rx_if;
  logic [7:0] byte_out;
  logic       byte_dc;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_out, byte_dc, byte_valid, input byte_ready);
  modport slave  (input byte_out, byte_dc, byte_valid, output byte_ready);
endinterface

// File: rtl/ssd1306_spi_rx.sv
// SPI (mode 0) snoop for the OLED bus: oversamples the lines, deserializes DC-tagged bytes into a FWFT FIFO.
// Define SSD1306_SPI_RX_STATS_EN to enable the accepted-byte counter rx_count.
module ssd1306_spi_rx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ss,
  input  logic                        scl,
  input  logic                        mosi,
  input  logic                        dc,
  ssd1306_spi_rx_if.master            rx,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        ovf_clr,
  output logic                        frame_err,
  output logic [15:0]                 rx_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] ss_sync, scl_sync, mosi_sync, dc_sync;
  logic ss_s, scl_s, mosi_s, dc_s;
  logic scl_prev, scl_rise_q, ss_q, mosi_q, dc_q;

  state_t state, state_next;
  logic [6:0] shift_reg, shift_next;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic       frame_err_next;
  logic       push;
  logic [8:0] push_word;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          full, pop, push_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync   <= '1;
      scl_sync  <= '0;
      mosi_sync <= '0;
      dc_sync   <= '0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc};
    end
  end

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign scl_s  = scl_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign dc_s   = dc_sync[SYNC_STAGES-1];

  // Edge detect, with the other synced lines delayed alongside so data, DC and ss stay aligned to the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_prev   <= 1'b0;
      scl_rise_q <= 1'b0;
      ss_q       <= 1'b1;
      mosi_q     <= 1'b0;
      dc_q       <= 1'b0;
    end else begin
      scl_prev   <= scl_s;
      scl_rise_q <= scl_s & ~scl_prev;
      ss_q       <= ss_s;
      mosi_q     <= mosi_s;
      dc_q       <= dc_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= bit_cnt_next;
      frame_err <= frame_err_next;
    end
  end

  // Only the low seven bits are ever needed: the eighth edge completes the word from mosi directly.
  always_comb begin
    state_next     = state;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt;
    frame_err_next = 1'b0;
    push           = 1'b0;
    push_word      = {dc_q, shift_reg, mosi_q};
    case (state)
      IDLE: begin
        if (!ss_q) state_next = SHIFT;
      end
      SHIFT: begin
        if (ss_q) begin
          state_next   = IDLE;
          bit_cnt_next = '0;
          if (bit_cnt != 3'd0) frame_err_next = 1'b1;
        end else if (scl_rise_q) begin
          shift_next   = {shift_reg[5:0], mosi_q};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) push = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign full    = (fifo_level == LW'(FIFO_DEPTH));
  assign pop     = rx.byte_valid & rx.byte_ready;
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_word;
  end

  // Occupancy is kept as its own counter because the pointers alone cannot tell full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 overflow <= 1'b0;
    else if (ovf_clr)        overflow <= 1'b0;
    else if (push & ~push_ok) overflow <= 1'b1;
  end

  assign rx.byte_valid = (fifo_level != '0);
  assign rx.byte_out   = rx.byte_valid ? mem[rptr][7:0] : 8'h00;
  assign rx.byte_dc    = rx.byte_valid ? mem[rptr][8]   : 1'b0;

`ifdef SSD1306_SPI_RX_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rx_count <= '0;
    else if (push_ok) rx_count <= rx_count + 16'd1;
  end
`else
  assign rx_count = '0;
`endif

endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// Randomized scoreboard bench for ssd1306_spi_rx: a queue model of the FIFO predicts every popped word.
// Honours SSD1306_SPI_RX_STATS_EN for the rx_count expectation.
module tb_ssd1306_spi_rx;
  localparam int FIFO_DEPTH  = 16;
  localparam int SYNC_STAGES = 2;
  localparam int LW          = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, ss, scl, mosi, dc, ovf_clr;
  logic [LW-1:0] fifo_level;
  logic          overflow, frame_err;
  logic [15:0]   rx_count;

  ssd1306_spi_rx_if bus ();

  ssd1306_spi_rx #(.FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .ss(ss), .scl(scl), .mosi(mosi), .dc(dc),
    .rx(bus), .fifo_level(fifo_level), .overflow(overflow), .ovf_clr(ovf_clr),
    .frame_err(frame_err), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  bit         exp_ovf = 1'b0;
  int         exp_rx = 0;
  int         fe_cycles = 0;
  bit         ready_rand = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge; the monitor samples on the falling edge.
  task automatic tick();
    @(posedge clk);
    #2;
    if (ready_rand) bus.byte_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_level"}, 32'(fifo_level), exp_q.size());
    checkOutput({tag, "_valid"}, 32'(bus.byte_valid), 32'(exp_q.size() != 0));
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
`ifdef SSD1306_SPI_RX_STATS_EN
    checkOutput({tag, "_rx_count"}, 32'(rx_count), exp_rx & 32'hFFFF);
`else
    checkOutput({tag, "_rx_count"}, 32'(rx_count), 0);
`endif
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_byte_out"}, 32'(bus.byte_out), 0);
    checkOutput({tag, "_byte_dc"}, 32'(bus.byte_dc), 0);
    checkOutput({tag, "_valid"}, 32'(bus.byte_valid), 0);
    checkOutput({tag, "_level"}, 32'(fifo_level), 0);
    checkOutput({tag, "_overflow"}, 32'(overflow), 0);
    checkOutput({tag, "_frame_err"}, 32'(frame_err), 0);
    checkOutput({tag, "_rx_count"}, 32'(rx_count), 0);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    ss = 1'b1; scl = 1'b0; mosi = 1'b0; dc = 1'b0; ovf_clr = 1'b0;
    bus.byte_ready = 1'b0;
    ready_rand = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_rx = 0;
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic sendBits(input logic [7:0] data, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = data[i];
      repeat (4) tick();
      scl = 1'b1;
      repeat (4) tick();
      scl = 1'b0;
    end
  endtask

  // One SPI byte; the model decides acceptance right after the push edge, when any same-edge pop is already counted.
  task automatic applyStimulus(input logic [7:0] data, input logic dcv, input bit pop_on_last, input bit lat_chk);
    dc = dcv;
    sendBits(data, 7);
    mosi = data[0];
    repeat (4) tick();
    scl = 1'b1;
    repeat (3) tick();
    if (lat_chk) checkOutput("latency_before_push", 32'(bus.byte_valid), 0);
    if (pop_on_last) bus.byte_ready = 1'b1;
    tick();
    if (pop_on_last) bus.byte_ready = 1'b0;
    if (lat_chk) checkOutput("latency_at_push", 32'(bus.byte_valid), 1);
    if (exp_q.size() < FIFO_DEPTH) begin
      exp_q.push_back({dcv, data});
      exp_rx++;
    end else if (!ovf_clr) begin
      exp_ovf = 1'b1;
    end
    repeat (4) tick();
    scl = 1'b0;
  endtask

  task automatic frameBegin();
    ss = 1'b0;
    repeat (4) tick();
  endtask

  task automatic frameEnd();
    repeat (4) tick();
    ss = 1'b1;
    repeat (8) tick();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    bus.byte_ready = 1'b1;
    while (bus.byte_valid && n < 4 * FIFO_DEPTH) begin
      tick();
      n++;
    end
    bus.byte_ready = 1'b0;
    tick();
    checkOutput({tag, "_drain_valid"}, 32'(bus.byte_valid), 0);
    checkOutput({tag, "_drain_queue"}, exp_q.size(), 0);
  endtask

  initial begin : monitor
    logic [8:0] w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_err) fe_cycles++;
        if (bus.byte_valid && bus.byte_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("pop_unexpected", 32'(bus.byte_valid), 0);
          end else begin
            w = exp_q.pop_front();
            checkOutput("pop_byte", 32'(bus.byte_out), 32'(w[7:0]));
            checkOutput("pop_dc", 32'(bus.byte_dc), 32'(w[8]));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin : stimulus
    int fe_before;
    int nbytes;
    applyReset();
    checkReset("reset");

    $display("[TB] single command byte 0xAE");
    frameBegin();
    applyStimulus(8'hAE, 1'b0, 1'b0, 1'b1);
    frameEnd();
    checkState("single");
    checkOutput("single_byte_out", 32'(bus.byte_out), 32'h0AE);
    checkOutput("single_byte_dc", 32'(bus.byte_dc), 0);
    bus.byte_ready = 1'b1;
    tick();
    bus.byte_ready = 1'b0;
    checkState("single_popped");

    $display("[TB] three data bytes in one frame");
    frameBegin();
    applyStimulus(8'h21, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h7F, 1'b1, 1'b0, 1'b0);
    frameEnd();
    checkState("three");
    checkOutput("three_head", 32'(bus.byte_out), 32'h21);
    drain("three");

    $display("[TB] overflow and ovf_clr");
    frameBegin();
    for (int i = 0; i < FIFO_DEPTH + 1; i++)
      applyStimulus(8'($urandom), 1'($urandom), 1'b0, 1'b0);
    checkState("ovf_set");
    ovf_clr = 1'b1;
    exp_ovf = 1'b0;
    applyStimulus(8'($urandom), 1'($urandom), 1'b0, 1'b0);
    ovf_clr = 1'b0;
    checkState("ovf_clr_priority");
    applyStimulus(8'($urandom), 1'($urandom), 1'b0, 1'b0);
    checkState("ovf_reflag");
    frameEnd();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    tick();
    checkState("ovf_cleared");

    $display("[TB] push and pop on the same edge while full");
    frameBegin();
    applyStimulus(8'($urandom), 1'($urandom), 1'b1, 1'b0);
    frameEnd();
    checkState("full_pushpop");
    drain("full_pushpop");

    $display("[TB] partial byte then 0x55");
    frameBegin();
    sendBits(8'hA5, 5);
    repeat (4) tick();
    ss = 1'b1;
    fe_before = fe_cycles;
    repeat (3) tick();
    checkOutput("frame_err_early", 32'(frame_err), 0);
    tick();
    checkOutput("frame_err_pulse", 32'(frame_err), 1);
    tick();
    checkOutput("frame_err_end", 32'(frame_err), 0);
    repeat (4) tick();
    checkOutput("frame_err_cycles", fe_cycles - fe_before, 1);
    checkState("partial");
    frameBegin();
    applyStimulus(8'h55, 1'b1, 1'b0, 1'b0);
    frameEnd();
    checkState("after_partial");
    checkOutput("after_partial_byte", 32'(bus.byte_out), 32'h55);
    drain("after_partial");

    $display("[TB] random frames with random ready");
    ready_rand = 1'b1;
    for (int f = 0; f < 6; f++) begin
      nbytes = $urandom_range(1, 4);
      frameBegin();
      for (int b = 0; b < nbytes; b++)
        applyStimulus(8'($urandom), 1'($urandom), 1'b0, 1'b0);
      frameEnd();
    end
    ready_rand = 1'b0;
    bus.byte_ready = 1'b0;
    tick();
    checkState("random");
    drain("random");

    $display("[TB] scl toggling with ss high");
    fe_before = fe_cycles;
    ss = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mosi = 1'($urandom);
      scl = ~scl;
      repeat (4) tick();
    end
    scl = 1'b0;
    repeat (6) tick();
    checkOutput("idle_scl_frame_err", fe_cycles - fe_before, 0);
    checkState("idle_scl");

    $display("[TB] reset mid-byte");
    frameBegin();
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);
    sendBits(8'hC3, 3);
    checkState("pre_reset");
    rst = 1'b1;
    #1;
    checkReset("mid_reset");
    applyReset();
    checkReset("post_reset");
    frameBegin();
    applyStimulus(8'h96, 1'b1, 1'b0, 1'b1);
    frameEnd();
    checkState("after_reset");
    drain("after_reset");

    checkOutput("frame_err_total", fe_cycles, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
